// File: rtl/bexkat1_intctl_pkg.sv
// Shared constants and helpers for the bexkat1 priority interrupt controller.
package bexkat1_intctl_pkg;

  localparam int unsigned NSRC = 7;

  localparam logic [1:0] INTCTL_PENDING = 2'd0;
  localparam logic [1:0] INTCTL_MASK    = 2'd1;
  localparam logic [1:0] INTCTL_FORCE   = 2'd2;
  localparam logic [1:0] INTCTL_STATUS  = 2'd3;

  localparam int unsigned STATUS_S_LSB     = 0;
  localparam int unsigned STATUS_INTER_LSB = 8;

  typedef logic [NSRC-1:0] src_t;

  // Highest set bit index plus one, 0 when nothing is set.
  function automatic logic [2:0] prio_enc(input src_t v);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (v[i]) r = 3'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/bexkat1_intctl_if.sv
// Bus slave signals between the bexkat1 CPU and the interrupt controller.
interface bexkat1_intctl_if;
  logic        cyc_i;
  logic        we_i;
  logic [1:0]  adr_i;
  logic [3:0]  sel_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack_o;

  modport slave (
    input  cyc_i, we_i, adr_i, sel_i, dat_i,
    output dat_o, ack_o
  );

  modport master (
    output cyc_i, we_i, adr_i, sel_i, dat_i,
    input  dat_o, ack_o
  );
endinterface

// File: rtl/bexkat1_intctl_irq_sync.sv
// Per-source synchroniser chain plus history flop; reports the synchronised
// level and a one-cycle rising-edge strobe.
module bexkat1_intctl_irq_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic irq_i,
  output logic s_o,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], irq_i};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign s_o    = r_sync[SYNC_STAGES-1];
  assign edge_o = s_o & ~r_hist;

endmodule

// File: rtl/bexkat1_intctl.sv
// Priority interrupt controller: latches 7 sources into pending, masks them and
// drives the highest enabled level to the CPU; software access via a bus slave.
module bexkat1_intctl
  import bexkat1_intctl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter src_t        EDGE_MASK   = 7'h7f
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  bexkat1_intctl_if.slave         bus,
  input  logic [NSRC-1:0]         irq_src,
  output logic [2:0]              inter_o
);

  src_t        w_s, w_edge;
  src_t        r_pending, r_mask, r_force;
  src_t        w_pending_d, w_mask_d, w_force_d, w_clr, w_set;
  logic        r_ack, w_access, w_wr;
  logic [31:0] r_dat, w_rdata;
  logic [2:0]  r_inter;
  logic        w_unused_bits;

  for (genvar g = 0; g < NSRC; g++) begin : g_sync
    bexkat1_intctl_irq_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .irq_i  (irq_src[g]),
      .s_o    (w_s[g]),
      .edge_o (w_edge[g])
    );
  end

  assign w_unused_bits = ^{bus.sel_i[3:1], bus.dat_i[31:NSRC]};

  always_comb begin
    w_access = bus.cyc_i & ~r_ack;
    w_wr     = w_access & bus.we_i & bus.sel_i[0];
    w_clr    = '0;
    w_set    = '0;
    w_mask_d = r_mask;
    if (w_wr) begin
      unique case (bus.adr_i)
        INTCTL_PENDING: w_clr    = bus.dat_i[NSRC-1:0];
        INTCTL_MASK:    w_mask_d = bus.dat_i[NSRC-1:0];
        INTCTL_FORCE:   w_set    = bus.dat_i[NSRC-1:0];
        default:        ;
      endcase
    end
    w_force_d = (r_force | w_set) & ~w_clr;
    // Edge sources: set beats clear. Level sources follow s unless forced.
    w_pending_d = (EDGE_MASK & (w_edge | w_set | (r_pending & ~w_clr)))
                | (~EDGE_MASK & (w_s | w_force_d));
  end

  always_comb begin
    w_rdata = '0;
    unique case (bus.adr_i)
      INTCTL_PENDING: w_rdata[NSRC-1:0] = r_pending;
      INTCTL_MASK:    w_rdata[NSRC-1:0] = r_mask;
      INTCTL_STATUS: begin
        w_rdata[STATUS_INTER_LSB +: 3]  = r_inter;
        w_rdata[STATUS_S_LSB +: NSRC]   = w_s;
      end
      default:        ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ack     <= 1'b0;
      r_dat     <= '0;
      r_pending <= '0;
      r_mask    <= '0;
      r_force   <= '0;
      r_inter   <= '0;
    end else begin
      r_ack     <= w_access;
      r_dat     <= w_access ? w_rdata : '0;
      r_pending <= w_pending_d;
      r_mask    <= w_mask_d;
      r_force   <= w_force_d;
      r_inter   <= prio_enc(r_pending & r_mask);
    end
  end

  assign bus.ack_o = r_ack;
  assign bus.dat_o = r_dat;
  assign inter_o   = r_inter;

endmodule

// File: tb/tb_bexkat1_intctl.sv
// Directed and random bench for bexkat1_intctl against a cycle reference model.
module tb_bexkat1_intctl;

  localparam int          S  = 2;
  localparam logic [6:0]  EM = 7'h7e;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [6:0] irq_src = '0;
  logic [2:0] inter_o;
  logic       mon_en = 1'b0;
  int         n_checks = 0;
  int         n_errors = 0;

  bexkat1_intctl_if bus();

  bexkat1_intctl #(
    .SYNC_STAGES(S),
    .EDGE_MASK  (EM)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .bus     (bus),
    .irq_src (irq_src),
    .inter_o (inter_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: sample history, edge history and the register file.
  typedef struct packed {
    logic [S-1:0][6:0] hist;
    logic [6:0]        h, pend, mask, frc;
    logic              ack;
    logic [31:0]       dat;
    logic [2:0]        inter;
  } mdl_t;

  mdl_t m;

  function automatic logic [2:0] highest(input logic [6:0] v);
    for (int i = 6; i >= 0; i--) if (v[i]) return 3'(i + 1);
    return 3'd0;
  endfunction

  function automatic mdl_t step(input mdl_t c, input logic [6:0] irq, input logic cyc,
                                input logic we, input logic [1:0] adr, input logic [3:0] sel,
                                input logic [31:0] wd);
    mdl_t        n = c;
    logic [6:0]  s = c.hist[S-1];
    logic [6:0]  rise = s & ~c.h;
    logic        acc = cyc && !c.ack;
    logic        wr = acc && we && sel[0];
    logic [6:0]  clr = (wr && adr == 2'd0) ? wd[6:0] : 7'd0;
    logic [6:0]  set = (wr && adr == 2'd2) ? wd[6:0] : 7'd0;
    logic [31:0] rd = 32'd0;
    for (int k = S - 1; k > 0; k--) n.hist[k] = c.hist[k-1];
    n.hist[0] = irq;
    n.h = s;
    if (wr && adr == 2'd1) n.mask = wd[6:0];
    n.frc = (c.frc | set) & ~clr;
    for (int i = 0; i < 7; i++) begin
      if (EM[i]) n.pend[i] = rise[i] | set[i] | (c.pend[i] & ~clr[i]);
      else       n.pend[i] = s[i] | n.frc[i];
    end
    case (adr)
      2'd0: rd = {25'd0, c.pend};
      2'd1: rd = {25'd0, c.mask};
      2'd3: rd = {21'd0, c.inter, 1'b0, s};
      default: rd = 32'd0;
    endcase
    n.ack   = acc;
    n.dat   = acc ? rd : 32'd0;
    n.inter = highest(c.pend & c.mask);
    return n;
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) m <= '0;
    else m <= step(m, irq_src, bus.cyc_i, bus.we_i, bus.adr_i, bus.sel_i, bus.dat_i);
  end

  always @(negedge clk_i) begin
    if (mon_en) check_eq("cycle", {28'd0, bus.ack_o, bus.dat_o, inter_o},
                         {28'd0, m.ack, m.dat, m.inter});
  end

  task automatic cyc_wait(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Single access; returns one idle cycle after the ack.
  task automatic xfer(input logic we, input logic [1:0] adr, input logic [3:0] sel,
                      input logic [31:0] wd, output logic [31:0] rd);
    bus.cyc_i = 1'b1; bus.we_i = we; bus.adr_i = adr; bus.sel_i = sel; bus.dat_i = wd;
    cyc_wait(1);
    check_eq("ack", bus.ack_o, 1);
    rd = bus.dat_o;
    bus.cyc_i = 1'b0; bus.we_i = 1'b0;
    cyc_wait(1);
  endtask

  task automatic wr(input logic [1:0] adr, input logic [31:0] wd);
    logic [31:0] d;
    xfer(1'b1, adr, 4'b0001, wd, d);
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] adr, input logic [31:0] exp);
    logic [31:0] d;
    xfer(1'b0, adr, 4'b0001, 32'd0, d);
    check_eq(tag, d, exp);
  endtask

  initial begin
    logic [31:0] d;
    bus.cyc_i = 0; bus.we_i = 0; bus.adr_i = 0; bus.sel_i = 0; bus.dat_i = 0;
    #1 rst_i = 1'b1;
    #20 rst_i = 1'b0;
    mon_en = 1'b1;
    cyc_wait(1);
    check_eq("reset_inter", inter_o, 0);
    check_eq("reset_ack", bus.ack_o, 0);
    rd_chk("reset_pending", 2'd0, 0);

    // Single edge pulse on source 2
    wr(2'd1, 32'h7f);
    irq_src = 7'h04;
    cyc_wait(1);
    irq_src = 7'h00;
    cyc_wait(2);
    check_eq("lat_before", inter_o, 0);
    cyc_wait(1);
    check_eq("lat_inter", inter_o, 3);
    rd_chk("pend_src2", 2'd0, 32'h04);
    rd_chk("status", 2'd3, 32'h300);
    wr(2'd0, 32'h04);

    // Two sources, priority and W1C
    irq_src = 7'h22;
    cyc_wait(1);
    irq_src = 7'h00;
    cyc_wait(4);
    check_eq("prio6", inter_o, 6);
    wr(2'd0, 32'h20);
    check_eq("prio2", inter_o, 2);
    wr(2'd0, 32'h02);
    check_eq("prio0", inter_o, 0);

    // Software force with mask gating
    wr(2'd1, 32'h00);
    wr(2'd2, 32'h40);
    rd_chk("force_pend", 2'd0, 32'h40);
    check_eq("force_masked", inter_o, 0);
    wr(2'd1, 32'h40);
    check_eq("force_unmask", inter_o, 7);
    wr(2'd0, 32'h40);

    // Level source 0 ignores W1C while high
    irq_src = 7'h01;
    wr(2'd1, 32'h01);
    cyc_wait(3);
    check_eq("level_on", inter_o, 1);
    wr(2'd0, 32'h01);
    cyc_wait(1);
    check_eq("level_w1c", inter_o, 1);
    irq_src = 7'h00;
    cyc_wait(3);
    check_eq("level_rel_before", inter_o, 1);
    cyc_wait(1);
    check_eq("level_rel", inter_o, 0);

    // Edge on source 3 coincides with W1C of bit 3
    irq_src = 7'h08;
    cyc_wait(2);
    xfer(1'b1, 2'd0, 4'b0001, 32'h08, d);
    rd_chk("edge_beats_clr", 2'd0, 32'h08);
    irq_src = 7'h00;
    wr(2'd0, 32'h08);

    // Held cyc gives ack every other cycle
    bus.cyc_i = 1'b1; bus.we_i = 1'b0; bus.adr_i = 2'd0; bus.sel_i = 4'h1;
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("ack_pat%0d", i), bus.ack_o, (i % 2));
      cyc_wait(1);
    end
    bus.cyc_i = 1'b0;
    cyc_wait(1);

    // sel_i[0] gates writes
    wr(2'd1, 32'h15);
    xfer(1'b1, 2'd1, 4'b0010, 32'h7f, d);
    rd_chk("sel_gate", 2'd1, 32'h15);

    // Random traffic, checked cycle by cycle against the model
    for (int t = 0; t < 2000; t++) begin
      if ($urandom_range(0, 3) == 0) irq_src = irq_src ^ (7'($urandom) & 7'($urandom));
      bus.cyc_i = 1'($urandom_range(0, 1));
      bus.we_i  = 1'($urandom_range(0, 1));
      bus.adr_i = 2'($urandom);
      bus.sel_i = 4'($urandom);
      bus.dat_i = $urandom;
      cyc_wait(1);
    end
    bus.cyc_i = 1'b0;
    irq_src = 7'h00;
    cyc_wait(4);

    // Reset during an ack
    wr(2'd1, 32'h7f);
    wr(2'd2, 32'h10);
    bus.cyc_i = 1'b1; bus.we_i = 1'b0; bus.adr_i = 2'd1; bus.sel_i = 4'h1;
    cyc_wait(1);
    check_eq("pre_rst_ack", bus.ack_o, 1);
    #2 rst_i = 1'b1;
    #1;
    check_eq("rst_ack", bus.ack_o, 0);
    check_eq("rst_dat", bus.dat_o, 0);
    check_eq("rst_inter", inter_o, 0);
    bus.cyc_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    cyc_wait(1);
    rd_chk("rst_pending", 2'd0, 0);
    rd_chk("rst_mask", 2'd1, 0);
    rd_chk("rst_status", 2'd3, 0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bexkat1_intctl.md
Name: bexkat1_intctl

Overview:
- Priority interrupt controller that feeds the bexkat1 CPU's 3-bit `inter` input.
- Collects 7 external interrupt sources, synchronises them and latches edges into a pending register.
- Masks the pending sources and drives the highest-priority pending, unmasked level.
- Software reads and controls it as a small bus slave on the CPU bus: cyc/we/ack, 32-bit data, byte selects.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each source synchroniser (minimum 2).
- EDGE_MASK, 7'h7f, per-source mode: 1 = rising-edge latched, 0 = level-sensitive.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- cyc_i  in  1  bus cycle request from the CPU.
- we_i  in  1  1 = write, 0 = read.
- adr_i  in  2  register select (word address bits [3:2]).
- sel_i  in  4  byte enables; only sel_i[0] is significant.
- dat_i  in  32  write data.
- dat_o  out  32  read data, valid while ack_o is high.
- ack_o  out  1  bus acknowledge.
- irq_src  in  7  asynchronous interrupt sources; bit i maps to level i+1.
- inter_o  out  3  to CPU `inter`; 0 = none, 7 = highest priority.

Behaviour:
- Reset: ack_o=0, dat_o=0, inter_o=0, pending=0, mask=0, all synchroniser stages=0, edge-history=0.
- Reset may assert mid-transaction; the cycle is abandoned with no register side effects.
- Synchroniser: irq_src[i] passes through SYNC_STAGES flops to give s[i]. A register h[i] holds the previous s[i]; edge = s & ~h.
  - h resets to 0, so a source already high when reset is released registers one edge.
- Pending, edge source (EDGE_MASK[i]=1):
  - Set on edge[i] or on a FORCE write with bit i set.
  - Cleared by a PENDING write with bit i set.
  - Edge and clear in the same cycle: set wins.
- Pending, level source (EDGE_MASK[i]=0):
  - pending[i] = s[i] OR force_latch[i].
  - force_latch is set by a FORCE write and cleared by a PENDING write with bit i set. Otherwise the W1C write has no effect while s[i] is high.
- inter_o: registered. Equals (index of the highest set bit of pending & mask) + 1, or 0 if that AND is 0.
  - Updates one cycle after pending or mask changes.
  - Edge-to-inter_o latency is SYNC_STAGES+2 cycles.
- Register map (adr_i):
  - 0 PENDING: read pending[6:0]; W1C.
  - 1 MASK: read/write, 1 = enabled.
  - 2 FORCE: write-1-to-set (software interrupt); reads 0.
  - 3 STATUS: read-only, {inter_o in [10:8], s[6:0] in [6:0]}.
  - Unused bits read 0.
- Bus handshake:
  - When cyc_i=1 and ack_o=0 at a clock edge, the next cycle has ack_o=1 (one cycle) and dat_o loaded.
  - A write commits at that same edge, and only if sel_i[0]=1.
  - ack_o is forced low the cycle after an ack. A CPU holding cyc_i high therefore sees one ack per two cycles, and each ack is a separate access.
  - dat_o returns to 0 when ack_o=0.
  - A write to STATUS is acked and ignored.
- Simultaneous PENDING W1C and FORCE cannot occur (single port).
- A MASK write and a new edge in the same cycle: both take effect; inter_o reflects both one cycle later.

Decomposition:
- Shared package bexkat1_intctl_pkg holds:
  - register index constants INTCTL_PENDING=0, INTCTL_MASK=1, INTCTL_FORCE=2, INTCTL_STATUS=3;
  - NSRC=7 and the STATUS field positions.
- Sub-module irq_sync: one per source, parameterised by SYNC_STAGES. Contains the synchroniser chain and the h register, and outputs s and edge.
- Priority encoder, pending logic and bus slave live in the top module.

Test Plan:
- Reset, then MASK=0x7f, pulse irq_src[2] for 1 cycle -> pending=0x04 and inter_o=3 exactly SYNC_STAGES+2 cycles after the pulse edge; STATUS read returns 0x300.
- irq_src[1] and [5] pulsed together, MASK=0x7f -> inter_o=6. W1C PENDING 0x20 -> inter_o=2. W1C 0x02 -> inter_o=0.
- MASK=0x00, FORCE write 0x40 -> pending=0x40, inter_o stays 0. MASK write 0x40 -> inter_o=7 one cycle later.
- EDGE_MASK=7'h7e, irq_src[0] held high, MASK=0x01 -> inter_o=1. W1C 0x01 -> inter_o remains 1. Release source -> inter_o=0 after SYNC_STAGES+2 cycles.
- Edge on source 3 lands in the same cycle as W1C 0x08 -> pending[3] remains 1.
- cyc_i held high for 6 cycles on a PENDING read -> ack_o pattern 0,1,0,1,0,1.
- Write with sel_i=4'b0010 to MASK -> mask unchanged.
- Assert rst_i in the cycle ack_o is high -> ack_o=0 and all registers 0 immediately.
